// File: rtl/npc_fetch_unit.sv
// npc_fetch_unit: fetch PC register, decode-stage branch/j/jr resolution with one delay slot,
// pending-redirect capture, exception entry and eret. Optional counters under NPC_PERF_EN.
module npc_fetch_unit #(
   parameter int unsigned  W        = 32,
   parameter logic [W-1:0] RESET_PC = W'(32'h0000_3000),
   parameter logic [W-1:0] EXC_VEC  = W'(32'h0000_4180)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         stall,
   output logic         if_req,
   output logic [W-1:0] if_addr,
   input  logic         if_ready,
   input  logic         d_valid,
   input  logic         d_br,
   input  logic [2:0]   d_brop,
   input  logic [W-1:0] d_pc4,
   input  logic [W-1:0] d_imm,
   input  logic [W-1:0] d_cmp1,
   input  logic [W-1:0] d_cmp2,
   input  logic         d_j,
   input  logic [25:0]  d_imm26,
   input  logic         d_jr,
   input  logic [W-1:0] d_jr_tgt,
   input  logic         exc_req,
   input  logic         eret_req,
   input  logic [W-1:0] epc,
   output logic         br_taken,
   output logic [31:0]  perf_br,
   output logic [31:0]  perf_taken
);

   typedef enum logic {ST_RUN, ST_PEND} state_t;

   state_t       r_state;
   logic [W-1:0] r_pc;
   logic [W-1:0] r_pend_tgt;
   logic         r_if_req;

   logic         w_taken;
   logic         w_lez;
   logic         w_redir;
   logic         w_fire;
   logic [W-1:0] w_br_tgt;
   logic [W-1:0] w_j_tgt;
   logic [W-1:0] w_tgt;

   // Signed compare against zero reduces to sign bit and zero test
   assign w_lez = d_cmp1[W-1] | (d_cmp1 == '0);

   always_comb begin
      w_taken = 1'b0;
      case (d_brop)
         3'd0:    w_taken = (d_cmp1 == d_cmp2);
         3'd1:    w_taken = (d_cmp1 != d_cmp2);
         3'd2:    w_taken = w_lez;
         3'd3:    w_taken = ~w_lez;
         3'd4:    w_taken = d_cmp1[W-1];
         3'd5:    w_taken = ~d_cmp1[W-1];
         default: w_taken = 1'b0;
      endcase
   end

   assign w_br_tgt = d_pc4 + (d_imm << 2);
   assign w_j_tgt  = {d_pc4[W-1:28], d_imm26, 2'b00};
   assign w_tgt    = d_j ? w_j_tgt : (d_jr ? d_jr_tgt : w_br_tgt);
   assign w_redir  = d_valid & ~stall & (d_j | d_jr | (d_br & w_taken));
   // A fetch only completes while a request is actually presented
   assign w_fire   = if_ready & r_if_req;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc       <= RESET_PC;
         r_state    <= ST_RUN;
         r_pend_tgt <= '0;
         r_if_req   <= 1'b0;
      end else begin
         r_if_req <= 1'b1;
         if (exc_req) begin
            r_pc    <= EXC_VEC;
            r_state <= ST_RUN;
         end else if (eret_req) begin
            r_pc    <= epc;
            r_state <= ST_RUN;
         end else if (!stall) begin
            case (r_state)
               ST_RUN: begin
                  if (w_redir && w_fire) begin
                     r_pc <= w_tgt;
                  end else if (w_redir) begin
                     r_pend_tgt <= w_tgt;
                     r_state    <= ST_PEND;
                  end else if (w_fire) begin
                     r_pc <= r_pc + W'(4);
                  end
               end
               ST_PEND: begin
                  if (w_fire) begin
                     r_pc    <= r_pend_tgt;
                     r_state <= ST_RUN;
                  end else if (w_redir) begin
                     r_pend_tgt <= w_tgt;
                  end
               end
               default: r_state <= ST_RUN;
            endcase
         end
      end
   end

   assign if_req   = r_if_req;
   assign if_addr  = r_pc;
   assign br_taken = d_valid & d_br & w_taken;

`ifdef NPC_PERF_EN
   logic [31:0] r_perf_br;
   logic [31:0] r_perf_taken;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_perf_br    <= '0;
         r_perf_taken <= '0;
      end else if (d_valid && !stall && d_br) begin
         r_perf_br <= r_perf_br + 32'd1;
         if (w_taken) r_perf_taken <= r_perf_taken + 32'd1;
      end
   end

   assign perf_br    = r_perf_br;
   assign perf_taken = r_perf_taken;
`else
   assign perf_br    = '0;
   assign perf_taken = '0;
`endif

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Bench for npc_fetch_unit: directed scenarios followed by random traffic against a reference model.
module tb_npc_fetch_unit;
   localparam int unsigned W = 32;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset_n, stall, if_req, if_ready, d_valid, d_br, d_j, d_jr;
   logic        exc_req, eret_req, br_taken;
   logic [2:0]  d_brop;
   logic [25:0] d_imm26;
   logic [31:0] if_addr, d_pc4, d_imm, d_cmp1, d_cmp2, d_jr_tgt, epc;
   logic [31:0] perf_br, perf_taken;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc, m_tgt, m_pbr, m_ptk;
   logic        m_req, m_pend;

   always #5 clk = ~clk;

   npc_fetch_unit dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .if_req(if_req), .if_addr(if_addr),
      .if_ready(if_ready), .d_valid(d_valid), .d_br(d_br), .d_brop(d_brop), .d_pc4(d_pc4),
      .d_imm(d_imm), .d_cmp1(d_cmp1), .d_cmp2(d_cmp2), .d_j(d_j), .d_imm26(d_imm26),
      .d_jr(d_jr), .d_jr_tgt(d_jr_tgt), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
      .br_taken(br_taken), .perf_br(perf_br), .perf_taken(perf_taken)
   );

   function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = int'(a);
      case (op)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return sa <= 0;
         3'd3:    return sa > 0;
         3'd4:    return sa < 0;
         3'd5:    return sa >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit          tk, redir, fire;
      logic [31:0] tgt;
      if (!reset_n) begin
         m_pc = RST_PC; m_req = 1'b0; m_pend = 1'b0; m_tgt = '0; m_pbr = '0; m_ptk = '0;
         return;
      end
      tk    = ref_taken(d_brop, d_cmp1, d_cmp2);
      redir = d_valid && !stall && (d_j || d_jr || (d_br && tk));
      if (d_j)       tgt = {d_pc4[31:28], d_imm26, 2'b00};
      else if (d_jr) tgt = d_jr_tgt;
      else           tgt = d_pc4 + d_imm * 32'd4;
      fire = if_ready && m_req;
      if (d_valid && !stall && d_br) begin
         m_pbr = m_pbr + 1;
         if (tk) m_ptk = m_ptk + 1;
      end
      if (exc_req)               begin m_pc = EXC_PC; m_pend = 1'b0; end
      else if (eret_req)         begin m_pc = epc;    m_pend = 1'b0; end
      else if (stall)            ;
      else if (m_pend && fire)   begin m_pc = m_tgt;  m_pend = 1'b0; end
      else if (m_pend && redir)  m_tgt = tgt;
      else if (redir && fire)    m_pc = tgt;
      else if (redir)            begin m_tgt = tgt;   m_pend = 1'b1; end
      else if (fire)             m_pc = m_pc + 32'd4;
      m_req = 1'b1;
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance both
   task automatic tick();
      logic [31:0] exp_br, exp_tk;
      @(negedge clk);
`ifdef NPC_PERF_EN
      exp_br = m_pbr; exp_tk = m_ptk;
`else
      exp_br = 32'd0; exp_tk = 32'd0;
`endif
      check("if_addr", if_addr, m_pc);
      check("if_req", 32'(if_req), 32'(m_req));
      check("br_taken", 32'(br_taken), 32'(d_valid && d_br && ref_taken(d_brop, d_cmp1, d_cmp2)));
      check("perf_br", perf_br, exp_br);
      check("perf_taken", perf_taken, exp_tk);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_decode();
      d_valid = 0; d_br = 0; d_brop = '0; d_pc4 = '0; d_imm = '0; d_cmp1 = '0; d_cmp2 = '0;
      d_j = 0; d_imm26 = '0; d_jr = 0; d_jr_tgt = '0;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 4))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'h5;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] exp_br, exp_tk, r;
      reset_n = 0; stall = 0; if_ready = 0; exc_req = 0; eret_req = 0; epc = '0;
      clear_decode();
      m_pc = RST_PC; m_req = 0; m_pend = 0; m_tgt = '0; m_pbr = '0; m_ptk = '0;
      #1;
      tick(); tick();
      check("rst_if_req", 32'(if_req), 32'd0);
      check("rst_if_addr", if_addr, 32'h3000);

      // Sequential fetch after release
      reset_n = 1; if_ready = 1;
      tick();
      check("seq0", if_addr, 32'h3000);
      tick();
      check("seq1", if_addr, 32'h3004);
      tick();
      check("seq2", if_addr, 32'h3008);

      // Taken BEQ backwards, then BNE falls through
      d_valid = 1; d_br = 1; d_brop = 3'd0; d_cmp1 = 32'd5; d_cmp2 = 32'd5;
      d_pc4 = 32'h3008; d_imm = 32'hFFFF_FFFE;
      #1 check("beq_taken", 32'(br_taken), 32'd1);
      tick();
      check("beq_tgt", if_addr, 32'h3000);
      d_brop = 3'd1;
      #1 check("bne_taken", 32'(br_taken), 32'd0);
      tick();
      check("bne_seq", if_addr, 32'h3004);

      // Zero-compare modes
      d_brop = 3'd2; d_cmp1 = 32'h8000_0000;
      #1 check("blez_neg", 32'(br_taken), 32'd1);
      d_brop = 3'd3; d_cmp1 = 32'h0;
      #1 check("bgtz_zero", 32'(br_taken), 32'd0);
      d_brop = 3'd5;
      #1 check("bgez_zero", 32'(br_taken), 32'd1);
      d_brop = 3'd7;
      #1 check("op7", 32'(br_taken), 32'd0);
      clear_decode();

      // j while fetch outstanding: held in PEND until if_ready
      if_ready = 0; d_valid = 1; d_j = 1; d_imm26 = 26'h100; d_pc4 = 32'h3008;
      tick();
      clear_decode();
      tick(); tick();
      check("pend_hold", if_addr, 32'h3004);
      if_ready = 1;
      tick();
      check("pend_load", if_addr, 32'h0000_0400);

      // Exception while PEND and stalled discards the pending target
      if_ready = 0; d_valid = 1; d_j = 1; d_imm26 = 26'h200;
      tick();
      clear_decode();
      stall = 1; exc_req = 1;
      tick();
      check("exc_vec", if_addr, EXC_PC);
      stall = 0; exc_req = 0; if_ready = 1;
      tick();
      check("exc_no_pend", if_addr, 32'h4184);
      eret_req = 1; epc = 32'h3010;
      tick();
      check("eret", if_addr, 32'h3010);
      eret_req = 0;

      // Counters: 3 branches (2 taken) plus one stalled branch cycle
      reset_n = 0;
      tick();
      reset_n = 1;
      d_valid = 1; d_br = 1; d_brop = 3'd0; d_cmp1 = 32'd7; d_cmp2 = 32'd7; d_pc4 = 32'h3008; d_imm = 32'd4;
      tick();
      d_brop = 3'd1;
      tick();
      d_brop = 3'd3; d_cmp1 = 32'd1;
      stall = 1;
      tick();
      stall = 0;
      tick();
      clear_decode();
      tick();
`ifdef NPC_PERF_EN
      exp_br = 32'd3; exp_tk = 32'd2;
`else
      exp_br = 32'd0; exp_tk = 32'd0;
`endif
      check("perf_br_total", perf_br, exp_br);
      check("perf_taken_total", perf_taken, exp_tk);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         stall    = ($urandom_range(0, 9) < 2);
         if_ready = ($urandom_range(0, 9) < 7);
         exc_req  = ($urandom_range(0, 39) == 0);
         eret_req = !exc_req && ($urandom_range(0, 39) == 0);
         epc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
         d_valid  = ($urandom_range(0, 9) < 6);
         r        = $urandom;
         d_br     = r[0]; d_j = r[1] & r[2] & r[3]; d_jr = r[4] & r[5] & r[6];
         d_brop   = r[10:8];
         d_cmp1   = pick_val();
         d_cmp2   = ($urandom_range(0, 1) == 1) ? d_cmp1 : pick_val();
         d_pc4    = $urandom & 32'hFFFF_FFFC;
         d_imm    = {{16{r[31]}}, r[31:16]};
         d_imm26  = 26'($urandom);
         d_jr_tgt = $urandom & 32'hFFFF_FFFC;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
